serial_adder_ctrl: RTL and testbench

Bit-serial addition controller that shares one `FA` full-adder cell between two requesters. It accepts a WIDTH-bit add request (x, y, carry-in), steps the single `FA` over WIDTH cycles with a carry flip-flop, and returns sum and carry-out with a one-cycle done pulse. When both requesters ask at once, a round-robin arbiter picks one. It is the area-minimal alternative to the ripple-carry chain and serves low-throughput arithmetic clients.

---
 rtl/serial_adder_ctrl_pkg.sv | 14 +
 rtl/serial_adder_ctrl_fa.sv | 16 +
 rtl/serial_adder_ctrl.sv | 140 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller:
// FSM state encoding and requester index constants.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full-adder cell shared by the serial adder datapath.
module FA (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  // Sum and carry of one bit position.
  always_comb begin
    s     = a ^ b ^ c_in;
    c_out = (a & b) | (a & c_in) | (b & c_in);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one FA cell stepped over WIDTH cycles,
// shared by two requesters through a round-robin arbiter.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic             cin0,
  input  logic             cin1,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done0,
  output logic             done1,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             last_gnt_q;
  logic             gnt_sel_q;
  logic             done0_q;
  logic             done1_q;
  logic             busy_q;

  logic             gnt_vld_d;
  logic             gnt_sel_d;
  logic [WIDTH-1:0] x_d;
  logic [WIDTH-1:0] y_d;
  logic             cin_d;
  logic [WIDTH-1:0] s_d;

  logic             fa_s;
  logic             fa_co;

  FA u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c_in  (carry_q),
    .s     (fa_s),
    .c_out (fa_co)
  );

  // Round-robin pick: on a tie the requester not served last wins.
  always_comb begin
    gnt_vld_d = req0 | req1;
    gnt_sel_d = REQ0;
    if (req0 && req1) begin
      gnt_sel_d = (last_gnt_q == REQ1) ? REQ0 : REQ1;
    end else if (req1) begin
      gnt_sel_d = REQ1;
    end
    x_d   = (gnt_sel_d == REQ1) ? x1   : x0;
    y_d   = (gnt_sel_d == REQ1) ? y1   : y0;
    cin_d = (gnt_sel_d == REQ1) ? cin1 : cin0;
    // Sum bits enter at the MSB so bit 0 ends up at the bottom after WIDTH shifts.
    s_d   = {fa_s, s_q[WIDTH-1:1]};
  end

  // Control FSM and serial datapath; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      s_q        <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      last_gnt_q <= REQ1;
      gnt_sel_q  <= REQ0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld_d) begin
            a_q        <= x_d;
            b_q        <= y_d;
            carry_q    <= cin_d;
            cnt_q      <= '0;
            gnt_sel_q  <= gnt_sel_d;
            last_gnt_q <= gnt_sel_d;
            busy_q     <= 1'b1;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          s_q     <= s_d;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            sum_q   <= s_d;
            cout_q  <= fa_co;
            done0_q <= (gnt_sel_q == REQ0);
            done1_q <= (gnt_sel_q == REQ1);
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sum   = sum_q;
  assign cout  = cout_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit and a 3-bit instance.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic       req0, req1, cin0, cin1;
  logic [7:0] x0, y0, x1, y1;
  logic [7:0] d8_sum;
  logic       d8_cout, d8_done0, d8_done1, d8_busy;

  logic       t_req0, t_req1, t_cin0, t_cin1;
  logic [2:0] t_x0, t_y0, t_x1, t_y1;
  logic [2:0] d3_sum;
  logic       d3_cout, d3_done0, d3_done1, d3_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .cin0(cin0), .cin1(cin1),
    .sum(d8_sum), .cout(d8_cout), .done0(d8_done0), .done1(d8_done1), .busy(d8_busy)
  );

  serial_adder_ctrl #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req0(t_req0), .req1(t_req1),
    .x0(t_x0), .y0(t_y0), .x1(t_x1), .y1(t_y1), .cin0(t_cin0), .cin1(t_cin1),
    .sum(d3_sum), .cout(d3_cout), .done0(d3_done0), .done1(d3_done1), .busy(d3_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit transaction from a single requester; checks latency, result, pulse.
  task automatic op8(input string tag, input logic sel, input logic [7:0] x,
                     input logic [7:0] y, input logic c, input logic [8:0] exp);
    int   k_done;
    logic other;
    @(negedge clk);
    if (sel) begin req1 = 1'b1; x1 = x; y1 = y; cin1 = c; end
    else     begin req0 = 1'b1; x0 = x; y0 = y; cin0 = c; end
    @(posedge clk);
    k_done = 0;
    other  = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) chk({tag, "_busy_up"}, 32'(d8_busy), 32'd1);
      if (sel ? d8_done0 : d8_done1) other = 1'b1;
      if (sel ? d8_done1 : d8_done0) begin k_done = k; break; end
    end
    chk({tag, "_latency"}, 32'(k_done), 32'd9);
    chk({tag, "_result"}, 32'({d8_cout, d8_sum}), 32'(exp));
    chk({tag, "_other_done"}, 32'(other), 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse_width"}, 32'(d8_done0 | d8_done1), 32'd0);
    chk({tag, "_busy_down"}, 32'(d8_busy), 32'd0);
  endtask

  // One 3-bit transaction from requester 0.
  task automatic op3(input string tag, input logic [2:0] x, input logic [2:0] y,
                     input logic c, input logic [3:0] exp);
    int k_done;
    @(negedge clk);
    t_req0 = 1'b1; t_x0 = x; t_y0 = y; t_cin0 = c;
    @(posedge clk);
    k_done = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (d3_done0) begin k_done = k; break; end
    end
    t_req0 = 1'b0;
    chk({tag, "_latency"}, 32'(k_done), 32'd4);
    chk({tag, "_result"}, 32'({d3_cout, d3_sum}), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, k0, k1;
    logic stable, early1, seen;
    int   sel_log[3];
    int   cyc_log[3];
    int   res_log[3];
    logic [3:0] exp3;

    rst_n = 1'b0;
    req0 = 0; req1 = 0; cin0 = 0; cin1 = 0; x0 = 0; y0 = 0; x1 = 0; y1 = 0;
    t_req0 = 0; t_req1 = 0; t_cin0 = 0; t_cin1 = 0; t_x0 = 0; t_y0 = 0; t_x1 = 0; t_y1 = 0;
    for (int i = 0; i < 3; i++) begin sel_log[i] = -1; cyc_log[i] = -1; res_log[i] = -1; end
    repeat (3) @(negedge clk);
    chk("rst_sum8", 32'({d8_cout, d8_sum}), 32'd0);
    chk("rst_ctrl8", 32'({d8_done0, d8_done1, d8_busy}), 32'd0);
    chk("rst_sum3", 32'({d3_cout, d3_sum}), 32'd0);
    chk("rst_ctrl3", 32'({d3_done0, d3_done1, d3_busy}), 32'd0);
    rst_n = 1'b1;

    op8("a5_3c", 1'b0, 8'hA5, 8'h3C, 1'b0, 9'h0E1);
    op8("ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, 9'h100);
    op8("7f_00_c", 1'b0, 8'h7F, 8'h00, 1'b1, 9'h080);
    op8("r1_only", 1'b1, 8'hC8, 8'h64, 1'b1, 9'h12D);

    // Reset 4 edges into RUN: outputs clear immediately, no done follows.
    @(negedge clk);
    req0 = 1'b1; x0 = 8'hFF; y0 = 8'h01; cin0 = 1'b0;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    req0  = 1'b0;
    #1;
    chk("midrst_busy", 32'(d8_busy), 32'd0);
    chk("midrst_result", 32'({d8_cout, d8_sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (d8_done0 | d8_done1) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    op8("rereq", 1'b0, 8'h5A, 8'h5A, 1'b1, 9'h0B5);

    // req1 arrives while requester 0 is running.
    @(negedge clk);
    req0 = 1'b1; x0 = 8'h0F; y0 = 8'h01; cin0 = 1'b0;
    @(posedge clk);
    stable = 1'b1; early1 = 1'b0; k0 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) begin req1 = 1'b1; x1 = 8'h33; y1 = 8'h44; cin1 = 1'b0; end
      if (d8_done1) early1 = 1'b1;
      if (d8_done0) begin k0 = k; break; end
      if (d8_sum !== 8'hB5) stable = 1'b0;
    end
    req0 = 1'b0;
    chk("busyreq_lat0", 32'(k0), 32'd9);
    chk("busyreq_sum_stable", 32'(stable), 32'd1);
    chk("busyreq_no_early1", 32'(early1), 32'd0);
    chk("busyreq_res0", 32'({d8_cout, d8_sum}), 32'h010);
    @(negedge clk);
    chk("busyreq_idle_gap", 32'(d8_busy), 32'd0);
    @(negedge clk);
    chk("busyreq_grant1", 32'(d8_busy), 32'd1);
    k1 = 0;
    for (int k = 3; k <= 20; k++) begin
      @(negedge clk);
      if (d8_done1) begin k1 = k; break; end
    end
    req1 = 1'b0;
    chk("busyreq_lat1", 32'(k1), 32'd10);
    chk("busyreq_res1", 32'({d8_cout, d8_sum}), 32'h077);

    // Both requesters held high: alternate 0,1,0 starting from reset.
    do_reset();
    @(negedge clk);
    req0 = 1'b1; x0 = 8'h12; y0 = 8'h34; cin0 = 1'b0;
    req1 = 1'b1; x1 = 8'hF0; y1 = 8'h20; cin1 = 1'b1;
    n = 0;
    for (int k = 0; k < 80 && n < 3; k++) begin
      @(negedge clk);
      if (d8_done0 | d8_done1) begin
        sel_log[n] = int'(d8_done1);
        cyc_log[n] = cyc;
        res_log[n] = int'({d8_cout, d8_sum});
        n++;
        if (n == 3) begin req0 = 1'b0; req1 = 1'b0; end
        @(negedge clk);
        chk("tie_pulse_width", 32'(d8_done0 | d8_done1), 32'd0);
      end
    end
    chk("tie_count", 32'(n), 32'd3);
    chk("tie_order0", 32'(sel_log[0]), 32'd0);
    chk("tie_order1", 32'(sel_log[1]), 32'd1);
    chk("tie_order2", 32'(sel_log[2]), 32'd0);
    chk("tie_gap01", 32'(cyc_log[1] - cyc_log[0]), 32'd10);
    chk("tie_gap12", 32'(cyc_log[2] - cyc_log[1]), 32'd10);
    chk("tie_res0", 32'(res_log[0]), 32'h046);
    chk("tie_res1", 32'(res_log[1]), 32'h111);
    chk("tie_res2", 32'(res_log[2]), 32'h046);

    // 3-bit instance: directed corner then exhaustive sweep.
    op3("w3_7_1_1", 3'd7, 3'd1, 1'b1, 4'b1001);
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        for (int c = 0; c < 2; c++) begin
          exp3 = 4'(a + b + c);
          op3("w3_sweep", 3'(a), 3'(b), 1'(c), exp3);
        end
      end
    end
    chk("w3_done1_idle", 32'(d3_done1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
